reg_file_bist: RTL and testbench

Built-in self-test engine for the RAT 32x8 register file: it drives the register file's write and read ports (DIN, ADRX, ADRY, RF_WR) and checks DX_OUT/DY_OUT. It writes a seeded pattern to every location, then reads every location back on both read ports at once and reports pass or the first failing address. At top level it sits beside the control unit, and a mux gives it ownership of the register file ports while BUSY is high.

---
 rtl/rat_bist_pkg.sv | 23 ++
 rtl/reg_file_bist.sv | 170 +++++++++++++++++
 tb/tb_reg_file_bist.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rat_bist_pkg.sv
// Shared definitions for the RAT register file BIST engine.
// Holds the register file geometry, the engine state encoding and the
// pattern generator used for both writing and checking.
package rat_bist_pkg;

  localparam int unsigned DEPTH = 32;  // register file locations
  localparam int unsigned AW    = 5;   // address width
  localparam int unsigned DW    = 8;   // data width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR     = 2'd1,
    RD     = 2'd2,
    DONE_S = 2'd3
  } state_t;

  // Test pattern for one location: the address zero-extended to DW, XOR seed.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] addr,
                                             input logic [DW-1:0] seed);
    return {{(DW-AW){1'b0}}, addr} ^ seed;
  endfunction

endpackage

// File: rtl/reg_file_bist.sv
// reg_file_bist: built-in self-test engine for the RAT 32x8 register file.
// Writes exp(a) = a ^ seed to every location, then reads all locations back
// on both read ports at once (X ascending, Y descending) and records pass or
// the first failing address.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   START, SEED       run request (sampled in IDLE) and pattern seed
//   DX_OUT, DY_OUT    register file read data, ports X and Y
//   DIN, ADRX, ADRY   register file write data and addresses (ADRX = write addr)
//   RF_WR             register file write enable
//   BUSY              engine owns the register file ports
//   DONE              one-cycle completion pulse
//   PASS, FAIL_ADR    result of the last run
module reg_file_bist
  import rat_bist_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [DW-1:0] SEED,
  input  logic [DW-1:0] DX_OUT,
  input  logic [DW-1:0] DY_OUT,
  output logic [DW-1:0] DIN,
  output logic [AW-1:0] ADRX,
  output logic [AW-1:0] ADRY,
  output logic          RF_WR,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [AW-1:0] FAIL_ADR
);

  // cnt is one bit wider than an address so the last location never aliases
  // to zero; the terminal compare uses the full width.
  localparam logic [AW:0]   LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_nxt;
  logic [DW-1:0] r_seed;
  logic [DW-1:0] w_seed_nxt;
  logic          r_pass;
  logic          w_pass_nxt;
  logic [AW-1:0] r_fail_adr;
  logic [AW-1:0] w_fail_adr_nxt;

  logic [AW-1:0] w_adr_x;
  logic [AW-1:0] w_adr_y;
  logic          w_mis_x;
  logic          w_mis_y;
  logic          w_last;

  assign w_adr_x = r_cnt[AW-1:0];
  assign w_adr_y = LAST_ADR - r_cnt[AW-1:0];
  assign w_last  = (r_cnt == LAST_CNT);
  // Read data only feeds the next-state logic, never an output directly.
  assign w_mis_x = (DX_OUT != exp_data(w_adr_x, r_seed));
  assign w_mis_y = (DY_OUT != exp_data(w_adr_y, r_seed));

  // State, counter, seed and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_seed     <= '0;
      r_pass     <= 1'b0;
      r_fail_adr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_seed     <= w_seed_nxt;
      r_pass     <= w_pass_nxt;
      r_fail_adr <= w_fail_adr_nxt;
    end
  end

  // Next-state, counter and result update.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_seed_nxt     = r_seed;
    w_pass_nxt     = r_pass;
    w_fail_adr_nxt = r_fail_adr;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_seed_nxt     = SEED;
          w_pass_nxt     = 1'b0;
          w_fail_adr_nxt = '0;
          w_cnt_nxt      = '0;
          w_state_nxt    = WR;
        end else begin
          w_state_nxt    = IDLE;
        end
      end
      WR: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RD;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      RD: begin
        // Port X is checked first so it wins when both ports mismatch.
        if (w_mis_x) begin
          w_fail_adr_nxt = w_adr_x;
          w_state_nxt    = DONE_S;
        end else if (w_mis_y) begin
          w_fail_adr_nxt = w_adr_y;
          w_state_nxt    = DONE_S;
        end else if (w_last) begin
          w_pass_nxt     = 1'b1;
          w_state_nxt    = DONE_S;
        end else begin
          w_cnt_nxt      = r_cnt + CNT_ONE;
        end
      end
      DONE_S: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Register file port decode from registered state and cnt; the async reset
  // forces IDLE, so RF_WR drops without waiting for a clock edge.
  always_comb begin
    DIN   = '0;
    ADRX  = '0;
    ADRY  = '0;
    RF_WR = 1'b0;
    BUSY  = 1'b0;
    DONE  = 1'b0;
    case (r_state)
      IDLE: begin
        BUSY = 1'b0;
      end
      WR: begin
        RF_WR = 1'b1;
        BUSY  = 1'b1;
        ADRX  = w_adr_x;
        DIN   = exp_data(w_adr_x, r_seed);
      end
      RD: begin
        BUSY  = 1'b1;
        ADRX  = w_adr_x;
        ADRY  = w_adr_y;
      end
      DONE_S: begin
        DONE  = 1'b1;
      end
      default: begin
        BUSY  = 1'b0;
      end
    endcase
  end

  assign PASS     = r_pass;
  assign FAIL_ADR = r_fail_adr;

endmodule

// File: tb/tb_reg_file_bist.sv
// Scoreboard bench for reg_file_bist with a behavioural 32x8 register file
// (sync write, async read) and an optional stuck-at-1 fault on reg[12] bit 3.
// Stimulus pushes the expected {PASS, FAIL_ADR, DONE cycle} per run; the
// monitor pops and compares on every DONE pulse.
module tb_reg_file_bist;

  typedef struct packed {
    logic        pass;
    logic [4:0]  fail_adr;
    logic [31:0] cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] seed;
  logic [7:0] dx_out;
  logic [7:0] dy_out;
  logic [7:0] din;
  logic [4:0] adrx;
  logic [4:0] adry;
  logic       rf_wr;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_adr;

  logic [7:0] rf [32];
  logic       stuck;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  reg_file_bist dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .START    (start),
    .SEED     (seed),
    .DX_OUT   (dx_out),
    .DY_OUT   (dy_out),
    .DIN      (din),
    .ADRX     (adrx),
    .ADRY     (adry),
    .RF_WR    (rf_wr),
    .BUSY     (busy),
    .DONE     (done),
    .PASS     (pass),
    .FAIL_ADR (fail_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural register file
  always @(posedge clk) begin
    if (rf_wr) rf[adrx] <= din;
  end

  always_comb begin
    dx_out = rf[adrx];
    if (stuck && adrx == 5'd12) dx_out = dx_out | 8'h08;
  end

  always_comb begin
    dy_out = rf[adry];
    if (stuck && adry == 5'd12) dy_out = dy_out | 8'h08;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: counts BUSY cycles, compares against the scoreboard on DONE
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("pass", 32'(pass), 32'(e.pass));
            chk("fail_adr", 32'(fail_adr), 32'(e.fail_adr));
            chk("done_cycle", 32'(busy_cnt), e.cyc);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic pulse_start(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_rf_wr"}, 32'(rf_wr), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_pass"}, 32'(pass), 32'd0);
    chk({name, "_fail_adr"}, 32'(fail_adr), 32'd0);
    chk({name, "_din"}, 32'(din), 32'd0);
    chk({name, "_adrx"}, 32'(adrx), 32'd0);
    chk({name, "_adry"}, 32'(adry), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    seed  = 8'h00;
    stuck = 1'b0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // seed 0x00: reg[i] = i
    sb.push_back('{pass: 1'b1, fail_adr: 5'd0, cyc: 32'd64});
    pulse_start(8'h00);
    wait_done("done_seed00");
    for (int i = 0; i < 32; i++) begin
      v = rf[i];
      chk($sformatf("rf_seed00[%0d]", i), 32'(v), 32'(i));
    end

    // seed 0xA5
    sb.push_back('{pass: 1'b1, fail_adr: 5'd0, cyc: 32'd64});
    pulse_start(8'hA5);
    wait_done("done_seedA5");
    v = rf[7];
    chk("rf_seedA5[7]", 32'(v), 32'hA2);
    v = rf[31];
    chk("rf_seedA5[31]", 32'(v), 32'hBA);

    // stuck-at-1 on reg[12] bit 3, seed 0xFF: fails at 12, DONE at cycle 45
    stuck = 1'b1;
    sb.push_back('{pass: 1'b0, fail_adr: 5'd12, cyc: 32'd45});
    pulse_start(8'hFF);
    wait_done("done_stuck");
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_pass", 32'(pass), 32'd0);
    chk("hold_fail_adr", 32'(fail_adr), 32'd12);

    // START held high: two full runs back to back, no mid-run restart
    sb.push_back('{pass: 1'b1, fail_adr: 5'd0, cyc: 32'd64});
    sb.push_back('{pass: 1'b1, fail_adr: 5'd0, cyc: 32'd64});
    @(negedge clk);
    seed  = 8'h5A;
    start = 1'b1;
    wait_done("done_held1");
    @(negedge clk);
    chk("held_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held_restart_busy", 32'(busy), 32'd1);
    wait_done("done_held2");
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_no_third_run", 32'(busy), 32'd0);

    // reset in WR at cnt=10
    pulse_start(8'h11);
    repeat (10) @(negedge clk);
    chk("mid_adrx", 32'(adrx), 32'd10);
    chk("mid_rf_wr", 32'(rf_wr), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle%0d", k), 32'(busy), 32'd0);
    end

    // SEED changes mid-run: pattern keeps the latched 0x3C
    sb.push_back('{pass: 1'b1, fail_adr: 5'd0, cyc: 32'd64});
    pulse_start(8'h3C);
    repeat (5) @(negedge clk);
    seed = 8'h00;
    wait_done("done_seed_change");
    v = rf[0];
    chk("rf_seed3C[0]", 32'(v), 32'h3C);
    v = rf[9];
    chk("rf_seed3C[9]", 32'(v), 32'h35);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
